// File: rtl/ttt_pkg.sv
// ttt_pkg: shared state encoding, cell/result codes and move legality for the turn scheduler
package ttt_pkg;
  typedef enum logic [2:0] {
    IDLE, PL_WAIT, PL_WRITE, PL_CHECK, PC_WAIT, PC_WRITE, PC_CHECK, DONE
  } state_t;
  localparam logic [1:0] EMPTY    = 2'b00;
  localparam logic [1:0] PLAYER   = 2'b01;
  localparam logic [1:0] COMPUTER = 2'b10;
  localparam logic [1:0] DRAW     = 2'b11;
  localparam logic [3:0] MAX_POS  = 4'd8;
  // shift rather than part-select so out-of-range codes never index past the board
  function automatic logic legal(input logic [17:0] board, input logic [3:0] pos);
    logic [17:0] s;
    s = board >> {pos, 1'b0};
    return pos <= MAX_POS && s[1:0] == EMPTY;
  endfunction
  function automatic logic [1:0] turn_of(input state_t s);
    return (s inside {PL_WAIT, PL_WRITE, PL_CHECK}) ? PLAYER :
           (s inside {PC_WAIT, PC_WRITE, PC_CHECK}) ? COMPUTER : EMPTY;
  endfunction
endpackage

// File: rtl/ttt_turn_timer.sv
// ttt_turn_timer: counts cycles a side spends waiting; expire flags the last allowed cycle
module ttt_turn_timer #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic run,
  input  logic clear,
  output logic expire
);
  logic [7:0] count;
  always_ff @(posedge clock)
    count <= (!reset || clear) ? 8'd0 : run ? count + 8'd1 : count;
  assign expire = run && count == 8'(TIMEOUT_CYCLES - 1);
endmodule

// File: rtl/ttt_turn_scheduler.sv
// ttt_turn_scheduler: player/computer turn FSM with registered board-write commands.
// Define TTT_TURN_TIMEOUT_EN to forfeit a side that waits TIMEOUT_CYCLES in its turn.
module ttt_turn_scheduler
  import ttt_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        new_game,
  input  logic        pl_req,
  input  logic [3:0]  pl_pos,
  input  logic        pc_req,
  input  logic [3:0]  pc_pos,
  input  logic [17:0] board,
  input  logic        win,
  input  logic        no_space,
  output logic        pl_ack,
  output logic        pc_ack,
  output logic        reject,
  output logic        wr_en,
  output logic [3:0]  wr_pos,
  output logic [1:0]  wr_who,
  output logic        board_clr,
  output logic [1:0]  turn,
  output logic [1:0]  result,
  output logic [3:0]  move_cnt
);
  state_t      state, state_n;
  logic        pl_ack_n, pc_ack_n, reject_n, wr_en_n, board_clr_n;
  logic [3:0]  wr_pos_n, move_cnt_n;
  logic [1:0]  wr_who_n, result_n;
  logic        expire;

`ifdef TTT_TURN_TIMEOUT_EN
  ttt_turn_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clock  (clock),
    .reset  (reset),
    .run    (state == PL_WAIT || state == PC_WAIT),
    .clear  (state_n != state || pl_ack_n || pc_ack_n),
    .expire (expire)
  );
`else
  assign expire = 1'b0;
`endif

  always_comb begin
    state_n     = state;
    pl_ack_n    = 1'b0;
    pc_ack_n    = 1'b0;
    reject_n    = 1'b0;
    wr_en_n     = 1'b0;
    wr_pos_n    = 4'd0;
    wr_who_n    = EMPTY;
    board_clr_n = 1'b0;
    result_n    = result;
    move_cnt_n  = move_cnt;
    case (state)
      IDLE, DONE: if (new_game) begin
        state_n     = PL_WAIT;
        board_clr_n = 1'b1;
        result_n    = EMPTY;
        move_cnt_n  = 4'd0;
      end
      PL_WAIT: if (pl_req) begin
        pl_ack_n = 1'b1;
        if (legal(board, pl_pos)) begin
          state_n    = PL_WRITE;
          wr_en_n    = 1'b1;
          wr_pos_n   = pl_pos;
          wr_who_n   = PLAYER;
          move_cnt_n = move_cnt + 4'd1;
        end else
          reject_n = 1'b1;
      end else if (expire) begin
        state_n  = DONE;
        result_n = COMPUTER;
      end
      PL_WRITE: state_n = PL_CHECK;
      PL_CHECK: begin
        state_n  = (win || no_space) ? DONE : PC_WAIT;
        result_n = win ? PLAYER : no_space ? DRAW : result;
      end
      PC_WAIT: if (pc_req) begin
        pc_ack_n = 1'b1;
        if (legal(board, pc_pos)) begin
          state_n    = PC_WRITE;
          wr_en_n    = 1'b1;
          wr_pos_n   = pc_pos;
          wr_who_n   = COMPUTER;
          move_cnt_n = move_cnt + 4'd1;
        end else
          reject_n = 1'b1;
      end else if (expire) begin
        state_n  = DONE;
        result_n = PLAYER;
      end
      PC_WRITE: state_n = PC_CHECK;
      PC_CHECK: begin
        state_n  = (win || no_space) ? DONE : PL_WAIT;
        result_n = win ? COMPUTER : no_space ? DRAW : result;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IDLE;
      pl_ack    <= 1'b0;
      pc_ack    <= 1'b0;
      reject    <= 1'b0;
      wr_en     <= 1'b0;
      wr_pos    <= 4'd0;
      wr_who    <= EMPTY;
      board_clr <= 1'b0;
      turn      <= EMPTY;
      result    <= EMPTY;
      move_cnt  <= 4'd0;
    end else begin
      state     <= state_n;
      pl_ack    <= pl_ack_n;
      pc_ack    <= pc_ack_n;
      reject    <= reject_n;
      wr_en     <= wr_en_n;
      wr_pos    <= wr_pos_n;
      wr_who    <= wr_who_n;
      board_clr <= board_clr_n;
      turn      <= turn_of(state_n);
      result    <= result_n;
      move_cnt  <= move_cnt_n;
    end
  end
endmodule

// File: tb/tb_ttt_turn_scheduler.sv
// tb_ttt_turn_scheduler: directed game scenarios against a board/detector environment model
module tb_ttt_turn_scheduler;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        new_game = 1'b0;
  logic        pl_req = 1'b0, pc_req = 1'b0;
  logic [3:0]  pl_pos = 4'd0, pc_pos = 4'd0;
  logic [17:0] bd = '0;
  logic        win, no_space, ovr_win = 1'b0, ovr_ns = 1'b0;
  logic        pl_ack, pc_ack, reject, wr_en, board_clr;
  logic [3:0]  wr_pos, move_cnt;
  logic [1:0]  wr_who, turn, result;
  int          total = 0, bad = 0;

  ttt_turn_scheduler #(.TIMEOUT_CYCLES(4)) dut (
    .clock(clock), .reset(reset), .new_game(new_game),
    .pl_req(pl_req), .pl_pos(pl_pos), .pc_req(pc_req), .pc_pos(pc_pos),
    .board(bd), .win(win), .no_space(no_space),
    .pl_ack(pl_ack), .pc_ack(pc_ack), .reject(reject),
    .wr_en(wr_en), .wr_pos(wr_pos), .wr_who(wr_who), .board_clr(board_clr),
    .turn(turn), .result(result), .move_cnt(move_cnt)
  );

  always #5 clock = ~clock;

  // board registers and line/full detectors the scheduler expects around it
  always @(posedge clock)
    if (board_clr) bd <= '0;
    else if (wr_en) bd[wr_pos*2 +: 2] <= wr_who;

  function automatic logic [1:0] c(input logic [17:0] b, input int i);
    return b[2*i +: 2];
  endfunction
  function automatic logic w3(input logic [17:0] b, input int i, input int j, input int k);
    return c(b, i) != 2'b00 && c(b, i) == c(b, j) && c(b, i) == c(b, k);
  endfunction

  always_comb begin
    win = ovr_win | w3(bd,0,1,2) | w3(bd,3,4,5) | w3(bd,6,7,8) | w3(bd,0,3,6)
        | w3(bd,1,4,7) | w3(bd,2,5,8) | w3(bd,0,4,8) | w3(bd,2,4,6);
    no_space = 1'b1;
    for (int i = 0; i < 9; i++) if (c(bd, i) == 2'b00) no_space = 1'b0;
    no_space = no_space | ovr_ns;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic start_game;
    new_game = 1'b1;
    tick;
    new_game = 1'b0;
    tick;
  endtask

  task automatic play_pl(input logic [3:0] p);
    pl_req = 1'b1;
    pl_pos = p;
    tick;
    pl_req = 1'b0;
    tick;
    tick;
  endtask

  task automatic play_pc(input logic [3:0] p);
    pc_req = 1'b1;
    pc_pos = p;
    tick;
    pc_req = 1'b0;
    tick;
    tick;
  endtask

  initial begin
    tick;
    tick;
    chk("rst_turn", turn, 2'b00);
    chk("rst_result", result, 2'b00);
    chk("rst_cnt", move_cnt, 4'd0);
    chk("rst_pulses", {pl_ack, pc_ack, reject, wr_en, board_clr}, 5'b0);
    reset = 1'b1;
    // first game: board clear then player takes the centre
    new_game = 1'b1;
    tick;
    new_game = 1'b0;
    chk("ng_clr", board_clr, 1'b1);
    chk("ng_turn", turn, 2'b01);
    tick;
    chk("ng_clr_one", board_clr, 1'b0);
    pl_req = 1'b1;
    pl_pos = 4'd4;
    tick;
    pl_req = 1'b0;
    chk("pl4_ack_wr", {pl_ack, reject, wr_en, wr_pos, wr_who}, {1'b1, 1'b0, 1'b1, 4'd4, 2'b01});
    chk("pl4_cnt", move_cnt, 4'd1);
    tick;
    chk("pl4_ack_once", {pl_ack, wr_en}, 2'b00);
    tick;
    chk("pl4_turn", turn, 2'b10);
    // computer: occupied cell, out-of-range code, then a legal move
    pc_req = 1'b1;
    pc_pos = 4'd4;
    tick;
    chk("pc4_rej", {pc_ack, reject, wr_en}, 3'b110);
    pc_pos = 4'd9;
    tick;
    chk("pc9_rej", {pc_ack, reject, wr_en, turn}, {3'b110, 2'b10});
    pc_pos = 4'd0;
    tick;
    pc_req = 1'b0;
    chk("pc0_acc", {pc_ack, reject, wr_en, wr_pos, wr_who}, {1'b1, 1'b0, 1'b1, 4'd0, 2'b10});
    chk("pc0_cnt", move_cnt, 4'd2);
    tick;
    tick;
    chk("pc0_turn", turn, 2'b01);
    // both requests during the player's turn
    pl_req = 1'b1;
    pc_req = 1'b1;
    pl_pos = 4'd1;
    pc_pos = 4'd2;
    tick;
    pl_req = 1'b0;
    chk("both_pl", {pl_ack, pc_ack}, 2'b10);
    tick;
    chk("both_pc_ign1", pc_ack, 1'b0);
    tick;
    chk("both_pc_ign2", {pc_ack, turn}, {1'b0, 2'b10});
    tick;
    pc_req = 1'b0;
    chk("both_pc_served", {pc_ack, wr_en, wr_pos}, {2'b11, 4'd2});
    chk("both_cnt", move_cnt, 4'd4);
    tick;
    tick;
    new_game = 1'b1;
    tick;
    new_game = 1'b0;
    chk("ng_midgame_ign", {board_clr, turn, move_cnt}, {1'b0, 2'b01, 4'd4});
    play_pl(4'd3);
    pc_req = 1'b1;
    pc_pos = 4'd5;
    tick;
    pc_req = 1'b0;
    chk("pc5_write", wr_en, 1'b1);
    // reset in PC_WRITE
    reset = 1'b0;
    tick;
    reset = 1'b1;
    chk("mid_rst_outs", {turn, result, move_cnt}, 8'h00);
    chk("mid_rst_pulses", {pl_ack, pc_ack, reject, wr_en, board_clr}, 5'b0);
    tick;
    chk("mid_rst_idle", turn, 2'b00);
    // player wins on the top row
    start_game;
    play_pl(4'd0);
    play_pc(4'd3);
    play_pl(4'd1);
    play_pc(4'd4);
    play_pl(4'd2);
    chk("win_result", {result, turn}, {2'b01, 2'b00});
    chk("win_cnt", move_cnt, 4'd5);
    pl_req = 1'b1;
    pc_req = 1'b1;
    pl_pos = 4'd5;
    pc_pos = 4'd6;
    tick;
    pl_req = 1'b0;
    pc_req = 1'b0;
    chk("done_ign", {pl_ack, pc_ack, reject, wr_en, result}, {4'b0, 2'b01});
    // drawn game restarted from DONE
    new_game = 1'b1;
    tick;
    new_game = 1'b0;
    chk("done_ng", {board_clr, result, move_cnt, turn}, {1'b1, 2'b00, 4'd0, 2'b01});
    tick;
    play_pl(4'd0);
    play_pc(4'd1);
    play_pl(4'd2);
    play_pc(4'd4);
    play_pl(4'd3);
    play_pc(4'd5);
    play_pl(4'd7);
    play_pc(4'd6);
    chk("draw_mid_turn", {turn, result}, {2'b01, 2'b00});
    play_pl(4'd8);
    chk("draw_result", {result, turn}, {2'b11, 2'b00});
    chk("draw_cnt", move_cnt, 4'd9);
    // win outranks no_space
    start_game;
    ovr_win = 1'b1;
    ovr_ns = 1'b1;
    play_pl(4'd0);
    ovr_win = 1'b0;
    ovr_ns = 1'b0;
    chk("prio_win", {result, move_cnt}, {2'b01, 4'd1});
    // idle player turn
    new_game = 1'b1;
    tick;
    new_game = 1'b0;
`ifdef TTT_TURN_TIMEOUT_EN
    tick;
    tick;
    tick;
    chk("to_before", {turn, result}, {2'b01, 2'b00});
    tick;
    chk("to_expired", {turn, result}, {2'b00, 2'b10});
`else
    repeat (1000) tick;
    chk("no_timeout", {turn, result}, {2'b01, 2'b00});
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
